// File: rtl/ps2_pkg.sv
// Shared constants, receiver state type and the set-2 scan-code lookup for the
// PS/2 ASCII reader.
package ps2_pkg;

  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_BACK  = 8'h08;
  localparam logic [7:0] KEY_ESC   = 8'h1B;
  localparam logic [7:0] KEY_UP    = 8'h1E;
  localparam logic [7:0] KEY_DOWN  = 8'h1F;
  localparam logic [7:0] KEY_LEFT  = 8'h1D;
  localparam logic [7:0] KEY_RIGHT = 8'h1C;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [7:0] code;
  } key_map_t;

  function automatic key_map_t lookup(input logic ext, input logic [7:0] sc,
                                      input logic shift);
    key_map_t   m;
    logic [7:0] letter;
    m      = '{hit: 1'b0, code: 8'h00};
    letter = 8'h00;
    if (ext) begin
      case (sc)
        8'h75:   m = '{hit: 1'b1, code: KEY_UP};
        8'h72:   m = '{hit: 1'b1, code: KEY_DOWN};
        8'h6B:   m = '{hit: 1'b1, code: KEY_LEFT};
        8'h74:   m = '{hit: 1'b1, code: KEY_RIGHT};
        8'h5A:   m = '{hit: 1'b1, code: KEY_ENTER};
        default: ;
      endcase
    end else begin
      case (sc)
        8'h1C: letter = "a";
        8'h32: letter = "b";
        8'h21: letter = "c";
        8'h23: letter = "d";
        8'h24: letter = "e";
        8'h2B: letter = "f";
        8'h34: letter = "g";
        8'h33: letter = "h";
        8'h43: letter = "i";
        8'h3B: letter = "j";
        8'h42: letter = "k";
        8'h4B: letter = "l";
        8'h3A: letter = "m";
        8'h31: letter = "n";
        8'h44: letter = "o";
        8'h4D: letter = "p";
        8'h15: letter = "q";
        8'h2D: letter = "r";
        8'h1B: letter = "s";
        8'h2C: letter = "t";
        8'h3C: letter = "u";
        8'h2A: letter = "v";
        8'h1D: letter = "w";
        8'h22: letter = "x";
        8'h35: letter = "y";
        8'h1A: letter = "z";
        8'h45: m = '{hit: 1'b1, code: "0"};
        8'h16: m = '{hit: 1'b1, code: "1"};
        8'h1E: m = '{hit: 1'b1, code: "2"};
        8'h26: m = '{hit: 1'b1, code: "3"};
        8'h25: m = '{hit: 1'b1, code: "4"};
        8'h2E: m = '{hit: 1'b1, code: "5"};
        8'h36: m = '{hit: 1'b1, code: "6"};
        8'h3D: m = '{hit: 1'b1, code: "7"};
        8'h3E: m = '{hit: 1'b1, code: "8"};
        8'h46: m = '{hit: 1'b1, code: "9"};
        8'h29: m = '{hit: 1'b1, code: 8'h20};
        8'h4E: m = '{hit: 1'b1, code: "-"};
        8'h5A: m = '{hit: 1'b1, code: KEY_ENTER};
        8'h66: m = '{hit: 1'b1, code: KEY_BACK};
        8'h76: m = '{hit: 1'b1, code: KEY_ESC};
        default: ;
      endcase
      if (letter != 8'h00) m = '{hit: 1'b1, code: shift ? letter - 8'h20 : letter};
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, 11-bit frame
// FSM with mid-frame timeout, parity/stop validation.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   fall, din;

  rx_state_t     state, state_nxt;
  logic [3:0]    bitcnt, bitcnt_nxt;
  logic [9:0]    shreg, shreg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // Synchronisers reset to the idle-high line level so release of rst never
  // fabricates a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking so every stage samples the pre-edge value of its neighbour.
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign din  = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      bitcnt <= bitcnt_nxt;
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    cnt_nxt    = cnt;
    byte_valid = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (fall && !din) begin
          state_nxt  = RECV;
          bitcnt_nxt = 4'd1;
        end
      end
      RECV: begin
        if (fall) begin
          shreg_nxt  = {din, shreg[9:1]};
          bitcnt_nxt = bitcnt + 4'd1;
          cnt_nxt    = '0;
          if (bitcnt == 4'd10) state_nxt = CHECK;
        end else if (cnt == TMO_LAST) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CHECK: begin
        // shreg holds {stop, parity, d7..d0}; odd parity over d0..d7 + parity
        state_nxt = IDLE;
        if ((^shreg[8:0]) && shreg[9]) byte_valid = 1'b1;
        else                           err        = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_byte = shreg[7:0];

endmodule

// File: rtl/ps2_ascii_reader.sv
// PS/2 set-2 keyboard reader: frame receiver plus make/break/E0/shift decoder.
// Define PS2_TYPEMATIC_FILTER_EN to suppress typematic repeats of a held key.
module ps2_ascii_reader
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii,
  output logic       key_break,
  output logic       ready,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid, rx_err;
  logic       ext, brk, shift;
  logic       is_shift, repeat_make;
  key_map_t   hit_map;

  ps2_frame_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .err       (rx_err)
  );

  assign hit_map  = lookup(ext, rx_byte, shift);
  assign is_shift = !ext && (rx_byte == SC_LSHIFT || rx_byte == SC_RSHIFT);

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       mem_valid;
  logic [8:0] mem_key;

  assign repeat_make = !brk && mem_valid && (mem_key == {ext, rx_byte});

  // Remembers the last reported make; only that key's break forgets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_key   <= '0;
    end else if (byte_valid && rx_byte != SC_BREAK && rx_byte != SC_EXT &&
                 !is_shift && hit_map.hit) begin
      if (!brk) begin
        mem_valid <= 1'b1;
        mem_key   <= {ext, rx_byte};
      end else if (mem_key == {ext, rx_byte}) begin
        mem_valid <= 1'b0;
      end
    end
  end
`else
  assign repeat_make = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ascii     <= 8'h00;
      key_break <= 1'b0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      shift     <= 1'b0;
    end else begin
      ready     <= 1'b0;
      frame_err <= rx_err;
      if (rx_err) begin
        // A lost byte may have been a prefix; drop pending E0/F0, keep shift.
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == SC_BREAK) begin
          brk <= 1'b1;
        end else if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else begin
          if (is_shift) begin
            shift <= !brk;
          end else if (hit_map.hit && !repeat_make) begin
            ascii     <= hit_map.code;
            key_break <= brk;
            ready     <= 1'b1;
          end
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/ps2_ascii_reader.md
Name: ps2_ascii_reader

Overview:
- Upstream stage of the game controller: receives PS/2 keyboard frames, decodes set-2 scan codes (make/break, E0 extended, shift) into the ASCII/control codes the controller consumes.
- Emits a one-cycle `ready` strobe with `ascii` and `key_break` held stable until the next strobe.
- Arrow keys map to private control codes:
  - Up 0x1E, Down 0x1F, Left 0x1D, Right 0x1C.
- Editing keys:
  - Enter 0x0D, Backspace 0x08, Esc 0x1B.

Parameters:
- TIMEOUT_CYC, 50000: clk cycles with no ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).
- SYNC_STAGES, 2: flip-flop depth of the ps2_clk/ps2_data synchronisers (min 2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ps2_clk  in  1  keyboard clock, asynchronous
- ps2_data  in  1  keyboard data, asynchronous
- ascii  out  8  decoded code of the last reported key
- key_break  out  1  1 = last report was a release, 0 = press
- ready  out  1  one-cycle strobe: new ascii/key_break valid
- frame_err  out  1  one-cycle strobe: frame discarded (parity, stop bit or timeout)

Behaviour:
- Reset:
  - Outputs: ascii=0x00, key_break=0, ready=0, frame_err=0.
  - Internal state: ext/brk/shift flags cleared, receiver FSM in IDLE, timeout counter 0.
  - Reset mid-frame discards the partial frame; no strobe follows.
- Input conditioning:
  - Inputs pass through SYNC_STAGES synchronisers.
  - A falling edge is detected as prev=1, cur=0 on the synchronised ps2_clk.
  - Data is sampled in the same cycle as the edge.
- Frame format: 11 bits — start(0), d0..d7 LSB first, odd parity, stop(1).
- Receiver FSM:
  - IDLE: waits for a falling edge with data=0, then goes to RECV, bitcnt=1. A falling edge with data=1 is ignored.
  - RECV: shifts in bits 2..11, bitcnt++ per edge. The timeout counter resets on every edge and increments otherwise. Reaching TIMEOUT_CYC pulses frame_err and returns to IDLE. After the 11th edge → CHECK.
  - CHECK (1 cycle): byte is valid if XOR(d0..d7, parity)=1 and stop=1. Otherwise frame_err pulses. Always returns to IDLE.
- Decoder, one step per valid byte:
  - F0: set brk, no report.
  - E0: set ext, no report.
  - 0x12/0x59, non-extended (shift): shift ← !brk, then clear ext/brk, no report.
  - Any other code: look up (ext, code, shift).
    - Mapped code: ascii ← value, key_break ← brk, ready pulses.
    - Unmapped code: no report.
    - ext and brk clear in both cases.
- Latency: ready/frame_err(parity/stop) assert exactly 2 clk after the cycle the 11th falling edge is detected. The ascii/key_break update lands in the same cycle as ready.
- Mapping, non-extended:
  - Letters:
    - 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
    - Lowercase; uppercase (−0x20) while shift=1.
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 → '0'..'9' (shift ignored).
  - 29 → 0x20 (space), 4E → '-', 5A → 0x0D, 66 → 0x08, 76 → 0x1B.
- Mapping, extended (E0):
  - 75 → 0x1E, 72 → 0x1F, 6B → 0x1D, 74 → 0x1C, 5A → 0x0D.
  - Non-extended 75/72/6B/74 (keypad) are unmapped.
- Break reports use the current shift state for case.
- frame_err also clears ext/brk, so the next code is not misattributed. Shift is kept.
- ready and frame_err are never asserted in the same cycle.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined: the module remembers the last reported make code (ext + code).
  - A repeated make of the same key with no intervening break is suppressed (no ready).
  - Its break clears the memory.
- Undefined: every typematic repeat produces a ready strobe with key_break=0.

Decomposition:
- Package ps2_pkg holds:
  - ASCII constants KEY_ENTER, KEY_BACK, KEY_ESC, KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT.
  - Scan-code constants SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59.
  - Receiver state typedef {IDLE, RECV, CHECK}.
- One sub-module, ps2_frame_rx: synchroniser, edge detect, receiver FSM, timeout. Outputs byte[7:0], byte_valid and err strobes.
- The top level holds the decoder and lookup.

Test Plan:
- Frame 1C then F0 1C → ready, ascii=0x61, key_break=0; then ready, ascii=0x61, key_break=1; no strobe on the F0 byte.
- E0 75, E0 F0 75 → ascii=0x1E with key_break=0, then 0x1E with key_break=1; keypad 75 alone → no ready.
- 12, 1C, F0 12, 1C → first report ascii=0x41, second ascii=0x61; the shift bytes produce no ready.
- Frame 5A with bad parity → frame_err pulse 2 clk after the 11th edge, no ready; following good 76 → ascii=0x1B.
- Stop after 5 bits, idle TIMEOUT_CYC cycles → frame_err at count TIMEOUT_CYC; next full frame 29 → ascii=0x20.
- rst asserted after the 6th bit of a frame → outputs 0 immediately; next clean frame 66 → ascii=0x08. With PS2_TYPEMATIC_FILTER_EN: 1D,1D,1D → exactly one ready (ascii=0x77).
